// File: rtl/scoreboard_pkg.sv
// Shared types for the scoreboard display path: player IDs, winner codes, FSM states,
// and the win-condition helper.
package scoreboard_pkg;

  typedef enum logic {
    P1 = 1'b0,
    P2 = 1'b1
  } player_e;

  typedef enum logic [1:0] {
    WinNone = 2'b00,
    WinP1   = 2'b01,
    WinP2   = 2'b10
  } winner_e;

  typedef enum logic {
    StPlaying  = 1'b0,
    StGameOver = 1'b1
  } sk_state_e;

  // Display controller states, consumed downstream of score_keeper.
  typedef enum logic [1:0] {
    DispIdle    = 2'b00,
    DispLoad    = 2'b01,
    DispRefresh = 2'b10
  } disp_state_e;

  // 9-bit compare so score + margin cannot wrap.
  function automatic logic has_won(input logic [7:0] own, input logic [7:0] other,
                                   input logic [7:0] win_points, input logic [7:0] win_margin);
    logic [8:0] own9;
    logic [8:0] need9;
    own9  = {1'b0, own};
    need9 = {1'b0, other} + {1'b0, win_margin};
    return (own9 >= {1'b0, win_points}) && (own9 >= need9);
  endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Button inputs and score/status outputs of score_keeper; slave is the keeper side.
interface score_keeper_if;
  logic       btn_p1_i;
  logic       btn_p2_i;
  logic       btn_undo_i;
  logic       btn_clear_i;
  logic [7:0] p1_score_o;
  logic [7:0] p2_score_o;
  logic [1:0] winner_o;
  logic       game_over_o;
  logic       event_o;
  logic [2:0] undo_level_o;

  modport slave (
    input  btn_p1_i, btn_p2_i, btn_undo_i, btn_clear_i,
    output p1_score_o, p2_score_o, winner_o, game_over_o, event_o, undo_level_o
  );

  modport master (
    output btn_p1_i, btn_p2_i, btn_undo_i, btn_clear_i,
    input  p1_score_o, p2_score_o, winner_o, game_over_o, event_o, undo_level_o
  );
endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchroniser, stable-count debouncer and rising-edge press pulse for one button.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic            sync1_q, sync2_q;
  logic            level_d, level_q;
  logic            level_dly_q;
  logic            press_d, press_q;
  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    // Count consecutive disagreeing cycles; any agreeing cycle restarts the count.
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    press_d = level_q & ~level_dly_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= press_d;
      cnt_q       <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/score_keeper.sv
// Debounced push-buttons to two saturating scores with LIFO undo history and game-over FSM.
module score_keeper
  import scoreboard_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic [7:0]  MAX_SCORE       = 8'd99,
  parameter logic [7:0]  WIN_POINTS      = 8'd11,
  parameter logic [7:0]  WIN_MARGIN      = 8'd2,
  parameter int unsigned UNDO_DEPTH      = 4
) (
  input logic           clk_i,
  input logic           rst_i,
  score_keeper_if.slave bus
);

  logic press_p1, press_p2, press_undo, press_clr;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p1 (
    .clk_i(clk_i), .rst_i(rst_i), .btn_i(bus.btn_p1_i), .press_o(press_p1)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p2 (
    .clk_i(clk_i), .rst_i(rst_i), .btn_i(bus.btn_p2_i), .press_o(press_p2)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_undo (
    .clk_i(clk_i), .rst_i(rst_i), .btn_i(bus.btn_undo_i), .press_o(press_undo)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk_i(clk_i), .rst_i(rst_i), .btn_i(bus.btn_clear_i), .press_o(press_clr)
  );

  sk_state_e             state_d, state_q;
  winner_e               winner_d, winner_q;
  logic [7:0]            p1_score_d, p1_score_q;
  logic [7:0]            p2_score_d, p2_score_q;
  logic [UNDO_DEPTH-1:0] hist_d, hist_q;  // bit i = player of entry i, 0 is oldest
  logic [2:0]            level_d, level_q;
  logic                  event_d, event_q;

  logic       win_chk;
  logic       hist_full;
  logic [2:0] lvl_m1;
  player_e    pl;

  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    p1_score_d = p1_score_q;
    p2_score_d = p2_score_q;
    hist_d     = hist_q;
    level_d    = level_q;
    event_d    = 1'b0;
    win_chk    = 1'b0;
    pl         = P1;
    lvl_m1     = level_q - 3'd1;
    hist_full  = (level_q == 3'(UNDO_DEPTH));

    if (press_clr) begin
      p1_score_d = '0;
      p2_score_d = '0;
      hist_d     = '0;
      level_d    = '0;
      winner_d   = WinNone;
      state_d    = StPlaying;
      event_d    = 1'b1;
    end else if (press_undo) begin
      if (level_q != 3'd0) begin
        for (int unsigned i = 0; i < UNDO_DEPTH; i++) begin
          if (3'(i) == lvl_m1) pl = player_e'(hist_q[i]);
        end
        level_d = lvl_m1;
        if (pl == P1) begin
          if (p1_score_q != 8'd0) p1_score_d = p1_score_q - 8'd1;
        end else begin
          if (p2_score_q != 8'd0) p2_score_d = p2_score_q - 8'd1;
        end
        event_d = 1'b1;
        win_chk = 1'b1;
      end
    end else if ((press_p1 ^ press_p2) && (state_q == StPlaying)) begin
      pl = press_p2 ? P2 : P1;
      if (((pl == P1) ? p1_score_q : p2_score_q) != MAX_SCORE) begin
        if (pl == P1) p1_score_d = p1_score_q + 8'd1;
        else          p2_score_d = p2_score_q + 8'd1;
        // When full, drop the oldest entry and append the newest at the top.
        if (hist_full) begin
          hist_d  = {pl, hist_q[UNDO_DEPTH-1:1]};
        end else begin
          for (int unsigned i = 0; i < UNDO_DEPTH; i++) begin
            if (3'(i) == level_q) hist_d[i] = pl;
          end
          level_d = level_q + 3'd1;
        end
        event_d = 1'b1;
        win_chk = 1'b1;
      end
    end

    if (win_chk) begin
      if (has_won(p1_score_d, p2_score_d, WIN_POINTS, WIN_MARGIN)) begin
        state_d  = StGameOver;
        winner_d = WinP1;
      end else if (has_won(p2_score_d, p1_score_d, WIN_POINTS, WIN_MARGIN)) begin
        state_d  = StGameOver;
        winner_d = WinP2;
      end else begin
        state_d  = StPlaying;
        winner_d = WinNone;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StPlaying;
      winner_q   <= WinNone;
      p1_score_q <= '0;
      p2_score_q <= '0;
      hist_q     <= '0;
      level_q    <= '0;
      event_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      p1_score_q <= p1_score_d;
      p2_score_q <= p2_score_d;
      hist_q     <= hist_d;
      level_q    <= level_d;
      event_q    <= event_d;
    end
  end

  assign bus.p1_score_o   = p1_score_q;
  assign bus.p2_score_o   = p2_score_q;
  assign bus.winner_o     = winner_q;
  assign bus.game_over_o  = (state_q == StGameOver);
  assign bus.event_o      = event_q;
  assign bus.undo_level_o = level_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: two instances (default win rules, and WIN_POINTS=120).
module tb_score_keeper;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic btn_p1 = 1'b0, btn_p2 = 1'b0, btn_undo = 1'b0, btn_clr = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   ev1 = 0;
  int   ev2 = 0;
  int   e0;

  always #5 clk_i = ~clk_i;

  score_keeper_if sk_if ();
  score_keeper_if sk2_if ();

  assign sk_if.btn_p1_i     = btn_p1;
  assign sk_if.btn_p2_i     = btn_p2;
  assign sk_if.btn_undo_i   = btn_undo;
  assign sk_if.btn_clear_i  = btn_clr;
  assign sk2_if.btn_p1_i    = btn_p1;
  assign sk2_if.btn_p2_i    = btn_p2;
  assign sk2_if.btn_undo_i  = btn_undo;
  assign sk2_if.btn_clear_i = btn_clr;

  score_keeper #(.DEBOUNCE_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(sk_if.slave)
  );
  score_keeper #(.DEBOUNCE_CYCLES(8), .WIN_POINTS(8'd120)) dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .bus(sk2_if.slave)
  );

  always @(posedge clk_i) begin
    if (sk_if.event_o === 1'b1) ev1 <= ev1 + 1;
    if (sk2_if.event_o === 1'b1) ev2 <= ev2 + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Hold long enough to debounce and apply, then release long enough to debounce back.
  task automatic press(input logic p1, input logic p2, input logic u, input logic c);
    btn_p1 = p1; btn_p2 = p2; btn_undo = u; btn_clr = c;
    step(14);
    btn_p1 = 1'b0; btn_p2 = 1'b0; btn_undo = 1'b0; btn_clr = 1'b0;
    step(14);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step(3);
    checks++;
    if ({sk_if.p1_score_o, sk_if.p2_score_o} !== 16'd0) begin
      errors++; $display("FAIL reset_scores: got %0d-%0d expected 0-0",
                         sk_if.p1_score_o, sk_if.p2_score_o);
    end
    checks++;
    if ({sk_if.winner_o, sk_if.game_over_o, sk_if.event_o, sk_if.undo_level_o} !== 7'd0) begin
      errors++; $display("FAIL reset_status: got w=%b go=%b ev=%b lvl=%0d expected all 0",
                         sk_if.winner_o, sk_if.game_over_o, sk_if.event_o, sk_if.undo_level_o);
    end
    rst_i = 1'b0;
    step(2);
  endtask

  task automatic test_bounce();
    e0 = ev1;
    for (int i = 0; i < 10; i++) begin
      btn_p1 = ~btn_p1;
      step(3);
    end
    btn_p1 = 1'b1;
    step(14);
    btn_p1 = 1'b0;
    step(14);
    checks++;
    if (ev1 - e0 !== 1) begin
      errors++; $display("FAIL bounce_events: got %0d expected 1", ev1 - e0);
    end
    checks++;
    if (sk_if.p1_score_o !== 8'd1 || sk_if.p2_score_o !== 8'd0) begin
      errors++; $display("FAIL bounce_score: got %0d-%0d expected 1-0",
                         sk_if.p1_score_o, sk_if.p2_score_o);
    end
  endtask

  task automatic test_win();
    press(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) press(1, 0, 0, 0);
    checks++;
    if (sk_if.game_over_o !== 1'b0) begin
      errors++; $display("FAIL win_at_10: got game_over=%b expected 0", sk_if.game_over_o);
    end
    press(1, 0, 0, 0);
    checks++;
    if (sk_if.p1_score_o !== 8'd11 || sk_if.game_over_o !== 1'b1 || sk_if.winner_o !== 2'b01)
    begin
      errors++; $display("FAIL win_11: got p1=%0d go=%b w=%b expected 11 1 01",
                         sk_if.p1_score_o, sk_if.game_over_o, sk_if.winner_o);
    end
    e0 = ev1;
    press(1, 0, 0, 0);
    checks++;
    if (sk_if.p1_score_o !== 8'd11 || ev1 - e0 !== 0) begin
      errors++; $display("FAIL win_12th_ignored: got p1=%0d events=%0d expected 11 0",
                         sk_if.p1_score_o, ev1 - e0);
    end
  endtask

  task automatic test_deuce();
    press(0, 0, 0, 1);
    checks++;
    if ({sk_if.p1_score_o, sk_if.winner_o, sk_if.game_over_o} !== 11'd0) begin
      errors++; $display("FAIL clear: got p1=%0d w=%b go=%b expected 0 00 0",
                         sk_if.p1_score_o, sk_if.winner_o, sk_if.game_over_o);
    end
    for (int i = 0; i < 10; i++) begin
      press(1, 0, 0, 0);
      press(0, 1, 0, 0);
    end
    press(1, 0, 0, 0);
    checks++;
    if (sk_if.p1_score_o !== 8'd11 || sk_if.p2_score_o !== 8'd10 || sk_if.game_over_o !== 1'b0)
    begin
      errors++; $display("FAIL deuce_11_10: got %0d-%0d go=%b expected 11-10 go=0",
                         sk_if.p1_score_o, sk_if.p2_score_o, sk_if.game_over_o);
    end
    press(1, 0, 0, 0);
    checks++;
    if (sk_if.p1_score_o !== 8'd12 || sk_if.winner_o !== 2'b01 || sk_if.game_over_o !== 1'b1)
    begin
      errors++; $display("FAIL deuce_12_10: got p1=%0d w=%b go=%b expected 12 01 1",
                         sk_if.p1_score_o, sk_if.winner_o, sk_if.game_over_o);
    end
  endtask

  task automatic test_undo();
    logic [15:0] exp_sc [3];
    exp_sc[0] = {8'd1, 8'd1};
    exp_sc[1] = {8'd1, 8'd0};
    exp_sc[2] = {8'd0, 8'd0};
    press(0, 0, 0, 1);
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    press(0, 1, 0, 0);
    checks++;
    if (sk_if.undo_level_o !== 3'd3) begin
      errors++; $display("FAIL undo_level_3: got %0d expected 3", sk_if.undo_level_o);
    end
    for (int i = 0; i < 3; i++) begin
      press(0, 0, 1, 0);
      checks++;
      if ({sk_if.p1_score_o, sk_if.p2_score_o} !== exp_sc[i]) begin
        errors++; $display("FAIL undo_step%0d: got %0d-%0d expected %0d-%0d", i,
                           sk_if.p1_score_o, sk_if.p2_score_o, exp_sc[i][15:8], exp_sc[i][7:0]);
      end
    end
    e0 = ev1;
    press(0, 0, 1, 0);
    checks++;
    if (ev1 - e0 !== 0 || sk_if.undo_level_o !== 3'd0) begin
      errors++; $display("FAIL undo_empty: got events=%0d lvl=%0d expected 0 0",
                         ev1 - e0, sk_if.undo_level_o);
    end
  endtask

  task automatic test_overflow();
    press(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) press(1, 0, 0, 0);
    checks++;
    if (sk_if.undo_level_o !== 3'd4) begin
      errors++; $display("FAIL ovf_level_sat: got %0d expected 4", sk_if.undo_level_o);
    end
    for (int i = 0; i < 4; i++) press(0, 0, 1, 0);
    checks++;
    if (sk_if.p1_score_o !== 8'd2 || sk_if.undo_level_o !== 3'd0) begin
      errors++; $display("FAIL ovf_4undo: got p1=%0d lvl=%0d expected 2 0",
                         sk_if.p1_score_o, sk_if.undo_level_o);
    end
    e0 = ev1;
    press(0, 0, 1, 0);
    checks++;
    if (sk_if.p1_score_o !== 8'd2 || ev1 - e0 !== 0) begin
      errors++; $display("FAIL ovf_5th_undo: got p1=%0d events=%0d expected 2 0",
                         sk_if.p1_score_o, ev1 - e0);
    end
    press(0, 0, 0, 1);
    for (int i = 0; i < 11; i++) press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    checks++;
    if (sk_if.p1_score_o !== 8'd10 || sk_if.game_over_o !== 1'b0 || sk_if.winner_o !== 2'b00)
    begin
      errors++; $display("FAIL undo_after_win: got p1=%0d go=%b w=%b expected 10 0 00",
                         sk_if.p1_score_o, sk_if.game_over_o, sk_if.winner_o);
    end
  endtask

  task automatic test_edge();
    press(0, 0, 0, 1);
    for (int i = 0; i < 99; i++) press(1, 0, 0, 0);
    checks++;
    if (sk2_if.p1_score_o !== 8'd99 || sk2_if.game_over_o !== 1'b0) begin
      errors++; $display("FAIL sat_99: got p1=%0d go=%b expected 99 0",
                         sk2_if.p1_score_o, sk2_if.game_over_o);
    end
    e0 = ev2;
    press(1, 0, 0, 0);
    checks++;
    if (sk2_if.p1_score_o !== 8'd99 || ev2 - e0 !== 0) begin
      errors++; $display("FAIL sat_100th: got p1=%0d events=%0d expected 99 0",
                         sk2_if.p1_score_o, ev2 - e0);
    end
    press(0, 0, 0, 1);
    press(1, 0, 0, 0);
    e0 = ev1;
    press(1, 1, 0, 0);
    checks++;
    if (sk_if.p1_score_o !== 8'd1 || sk_if.p2_score_o !== 8'd0 || ev1 - e0 !== 0) begin
      errors++; $display("FAIL both_pressed: got %0d-%0d events=%0d expected 1-0 0",
                         sk_if.p1_score_o, sk_if.p2_score_o, ev1 - e0);
    end
    // Reset asserted between edges must clear outputs without a clock.
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    checks++;
    if ({sk_if.p1_score_o, sk_if.p2_score_o, sk_if.winner_o, sk_if.game_over_o,
         sk_if.event_o, sk_if.undo_level_o} !== 23'd0) begin
      errors++; $display("FAIL async_reset: got p1=%0d lvl=%0d expected all 0",
                         sk_if.p1_score_o, sk_if.undo_level_o);
    end
    btn_p1 = 1'b1;
    step(3);
    rst_i = 1'b0;
    e0 = ev1;
    step(16);
    btn_p1 = 1'b0;
    step(14);
    checks++;
    if (sk_if.p1_score_o !== 8'd1 || ev1 - e0 !== 1) begin
      errors++; $display("FAIL held_through_reset: got p1=%0d events=%0d expected 1 1",
                         sk_if.p1_score_o, ev1 - e0);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_win();
    test_deuce();
    test_undo();
    test_overflow();
    test_edge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
